// File: rtl/stream_sink_checker.sv
// -----------------------------------------------------------------------------
// stream_sink_checker
//   Consumer-end endpoint for a valid/ready stream. It drives a registered
//   ready with a selectable backpressure pattern and checks accepted data
//   against an incrementing expected sequence. It also flags upstream protocol
//   violations, where valid or data is not held while stalled.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   i_enable        1 = RUN, 0 = IDLE
//   i_clear         synchronous clear of counters, sticky flags, stall and LFSR
//   i_start_value   first expected value, loaded on the IDLE->RUN edge
//   i_bp_mode       0 always ready, 1 LFSR random, 2 alternate, 3 never ready
//   i_in_valid      source valid
//   o_in_ready      sink ready (registered)
//   i_in_data       source data
//   o_beat_count    accepted beats, saturating
//   o_err_count     data mismatches, saturating
//   o_data_err      sticky data mismatch flag
//   o_proto_err     sticky source protocol violation flag
// -----------------------------------------------------------------------------
module stream_sink_checker #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_enable,
   input  logic                  i_clear,
   input  logic [DATA_WIDTH-1:0] i_start_value,
   input  logic [1:0]            i_bp_mode,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic [DATA_WIDTH-1:0] i_in_data,
   output logic [CNT_WIDTH-1:0]  o_beat_count,
   output logic [CNT_WIDTH-1:0]  o_err_count,
   output logic                  o_data_err,
   output logic                  o_proto_err
);

   localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {StIdle, StRun} state_e;

   state_e                r_state;
   state_e                w_state_next;
   logic                  r_ready;
   logic                  w_ready_next;
   logic                  w_start;
   logic                  r_alt;
   logic [15:0]           r_lfsr;
   logic [DATA_WIDTH-1:0] r_expected;
   logic [DATA_WIDTH-1:0] r_held;
   logic                  r_stalled;
   logic [CNT_WIDTH-1:0]  r_beat_count;
   logic [CNT_WIDTH-1:0]  r_err_count;
   logic                  r_data_err;
   logic                  r_proto_err;

   logic w_run;
   logic w_accept;
   logic w_stall;
   logic w_match;
   logic w_viol;
   logic w_lfsr_fb;

   assign w_run     = (r_state == StRun);
   assign w_accept  = i_in_valid & r_ready;
   assign w_stall   = i_in_valid & ~r_ready;
   assign w_match   = (i_in_data == r_expected);
   // A registered stall must be followed by the same valid beat.
   assign w_viol    = r_stalled & (~i_in_valid | (i_in_data != r_held));
   assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_ready <= w_ready_next;
      end
   end

   // Next state and next ready; ready drops on the same edge RUN is left
   always_comb begin
      w_state_next = r_state;
      w_ready_next = 1'b0;
      w_start      = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_enable) begin
               w_state_next = StRun;
               w_start      = 1'b1;
            end
         end
         StRun: begin
            if (!i_enable) begin
               w_state_next = StIdle;
            end else begin
               unique case (i_bp_mode)
                  2'd0:    w_ready_next = 1'b1;
                  2'd1:    w_ready_next = r_lfsr[0];
                  2'd2:    w_ready_next = r_alt;
                  default: w_ready_next = 1'b0;
               endcase
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Datapath, counters and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alt        <= 1'b0;
         r_lfsr       <= LFSR_SEED;
         r_expected   <= '0;
         r_held       <= '0;
         r_stalled    <= 1'b0;
         r_beat_count <= '0;
         r_err_count  <= '0;
         r_data_err   <= 1'b0;
         r_proto_err  <= 1'b0;
      end else begin
         if (w_run) r_alt <= ~r_alt;
         if (w_stall) r_held <= i_in_data;

         // Expected tracks the stream even in a clear cycle
         if (w_start) begin
            r_expected <= i_start_value;
         end else if (w_accept) begin
            r_expected <= w_match ? (r_expected + DATA_ONE) : (i_in_data + DATA_ONE);
         end

         if (i_clear) begin
            r_lfsr       <= LFSR_SEED;
            r_stalled    <= 1'b0;
            r_beat_count <= '0;
            r_err_count  <= '0;
            r_data_err   <= 1'b0;
            r_proto_err  <= 1'b0;
         end else begin
            if (w_run) r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            r_stalled <= w_stall;
            if (w_accept && !(&r_beat_count)) r_beat_count <= r_beat_count + CNT_ONE;
            if (w_accept && !w_match) begin
               r_data_err <= 1'b1;
               if (!(&r_err_count)) r_err_count <= r_err_count + CNT_ONE;
            end
            if (w_viol) r_proto_err <= 1'b1;
         end
      end
   end

   assign o_in_ready   = r_ready;
   assign o_beat_count = r_beat_count;
   assign o_err_count  = r_err_count;
   assign o_data_err   = r_data_err;
   assign o_proto_err  = r_proto_err;

endmodule

// File: tb/tb_stream_sink_checker.sv
// -----------------------------------------------------------------------------
// tb_stream_sink_checker
//   Self-checking bench for stream_sink_checker. A cycle-level reference model
//   built from the sink's rules predicts ready, counters and flags. Directed
//   scenarios are followed by a randomized phase with a mostly compliant source.
// -----------------------------------------------------------------------------
module tb_stream_sink_checker;
   localparam int unsigned DW   = 32;
   localparam int unsigned CW   = 8;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam int unsigned CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          clear = 1'b0;
   logic [DW-1:0] start_value = '0;
   logic [1:0]    bp_mode = 2'd0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] beat_count;
   logic [CW-1:0] err_count;
   logic          data_err;
   logic          proto_err;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model state
   bit            m_run, m_ready, m_alt, m_derr, m_perr, m_stalled;
   int unsigned   m_lfsr, m_beats, m_errs;
   logic [DW-1:0] m_exp, m_held;
   logic [DW-1:0] s_data;

   always #5 clk = ~clk;

   stream_sink_checker #(
      .DATA_WIDTH (DW),
      .CNT_WIDTH  (CW),
      .LFSR_SEED  (SEED)
   ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_enable      (enable),
      .i_clear       (clear),
      .i_start_value (start_value),
      .i_bp_mode     (bp_mode),
      .i_in_valid    (in_valid),
      .o_in_ready    (in_ready),
      .i_in_data     (in_data),
      .o_beat_count  (beat_count),
      .o_err_count   (err_count),
      .o_data_err    (data_err),
      .o_proto_err   (proto_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_all();
      chk("in_ready", 32'(in_ready), 32'(m_ready));
      chk("beat_count", 32'(beat_count), m_beats);
      chk("err_count", 32'(err_count), m_errs);
      chk("data_err", 32'(data_err), 32'(m_derr));
      chk("proto_err", 32'(proto_err), 32'(m_perr));
   endtask

   task automatic model_reset();
      m_run = 0; m_ready = 0; m_alt = 0; m_derr = 0; m_perr = 0; m_stalled = 0;
      m_lfsr = 32'(SEED); m_beats = 0; m_errs = 0; m_exp = '0; m_held = '0;
   endtask

   // One rising edge of the sink, evaluated from the current inputs
   task automatic model_edge();
      bit acc, stall, viol, ok, rdy;
      int unsigned fb;
      acc   = in_valid && m_ready;
      stall = in_valid && !m_ready;
      viol  = m_stalled && (!in_valid || in_data != m_held);
      ok    = (in_data == m_exp);
      rdy   = 0;
      if (m_run && enable) begin
         case (bp_mode)
            2'd0: rdy = 1;
            2'd1: rdy = (m_lfsr % 2) == 1;
            2'd2: rdy = m_alt;
            default: rdy = 0;
         endcase
      end
      if (!m_run && enable) m_exp = start_value;
      else if (acc) m_exp = ok ? m_exp + 1 : in_data + 1;
      if (clear) begin
         m_beats = 0; m_errs = 0; m_derr = 0; m_perr = 0; m_stalled = 0;
         m_lfsr = 32'(SEED);
      end else begin
         if (acc && m_beats < CMAX) m_beats++;
         if (acc && !ok) begin
            m_derr = 1;
            if (m_errs < CMAX) m_errs++;
         end
         if (viol) m_perr = 1;
         m_stalled = stall;
         if (m_run) begin
            fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) % 2;
            m_lfsr = ((m_lfsr * 2) + fb) % 65536;
         end
      end
      if (stall) m_held = in_data;
      if (m_run) m_alt = !m_alt;
      m_run   = enable;
      m_ready = rdy;
   endtask

   // Called at a falling edge with inputs already set for this cycle
   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
      chk_all();
      @(negedge clk);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear at once
   task automatic do_reset();
      rst_n = 0;
      enable = 0; clear = 0; in_valid = 0; in_data = '0; s_data = '0;
      model_reset();
      #2;
      chk_all();
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic go_run(input logic [DW-1:0] sv, input logic [1:0] mode);
      enable = 1; start_value = sv; bp_mode = mode;
      cyc();
      cyc();
   endtask

   // Source: holds a stalled beat, otherwise offers the next sequence value
   task automatic src_step(input int pv, input int p_bad, input int p_viol);
      bit acc;
      acc = in_valid && m_ready;
      cyc();
      if (acc) s_data = s_data + 1;
      if (in_valid && !acc) begin
         if ($urandom_range(99) < p_viol) begin
            if ($urandom_range(1) == 0) in_valid = 0;
            else in_data = in_data ^ 32'h1;
         end
      end else begin
         in_valid = $urandom_range(99) < pv;
         in_data  = ($urandom_range(99) < p_bad) ? $urandom : s_data;
      end
   endtask

   initial begin
      logic [DW-1:0] t2 [4];
      logic [DW-1:0] t3 [4];
      t2[0] = 1; t2[1] = 2; t2[2] = 9; t2[3] = 10;
      t3[0] = 32'hFFFF_FFFE; t3[1] = 32'hFFFF_FFFF; t3[2] = 0; t3[3] = 1;

      model_reset();
      @(negedge clk);
      do_reset();

      // T1: clean in-order stream
      go_run(5, 0);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1; in_data = 5 + i;
         cyc();
      end
      in_valid = 0;
      cyc();
      chk("t1_beats", 32'(beat_count), 10);
      chk("t1_errs", 32'(err_count), 0);
      chk("t1_ready", 32'(in_ready), 1);
      chk("t1_flags", 32'({data_err, proto_err}), 0);

      // T2: one gap in the sequence, resync afterwards
      do_reset();
      go_run(1, 0);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1; in_data = t2[i];
         cyc();
      end
      in_valid = 0;
      cyc();
      chk("t2_errs", 32'(err_count), 1);
      chk("t2_data_err", 32'(data_err), 1);
      chk("t2_beats", 32'(beat_count), 4);

      // T3: expected-value wrap
      do_reset();
      go_run(32'hFFFF_FFFE, 0);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1; in_data = t3[i];
         cyc();
      end
      in_valid = 0;
      cyc();
      chk("t3_errs", 32'(err_count), 0);
      chk("t3_beats", 32'(beat_count), 4);

      // T4: protocol violation under permanent backpressure
      do_reset();
      go_run(0, 3);
      in_valid = 1; in_data = 7;
      cyc();
      in_valid = 0;
      cyc();
      chk("t4_proto", 32'(proto_err), 1);
      chk("t4_beats", 32'(beat_count), 0);
      clear = 1;
      cyc();
      clear = 0;
      in_valid = 1; in_data = 7;
      repeat (4) cyc();
      chk("t4_proto_held", 32'(proto_err), 0);

      // T5: LFSR backpressure with a compliant source
      do_reset();
      go_run(0, 1);
      in_valid = 1; in_data = 0;
      repeat (1000) src_step(70, 0, 0);
      chk("t5_errs", 32'(err_count), 0);
      chk("t5_flags", 32'({data_err, proto_err}), 0);

      // T6: clear on an accepting edge, then reset mid-stream
      do_reset();
      go_run(100, 0);
      in_valid = 1; in_data = 100;
      cyc();
      in_data = 101; clear = 1;
      cyc();
      clear = 0;
      chk("t6_cleared", 32'(beat_count), 0);
      in_data = 102;
      cyc();
      chk("t6_after_clear_beats", 32'(beat_count), 1);
      chk("t6_after_clear_errs", 32'(err_count), 0);
      in_data = 103;
      do_reset();
      chk("t6_rst_ready", 32'(in_ready), 0);
      chk("t6_rst_beats", 32'(beat_count), 0);
      enable = 1; bp_mode = 0;
      cyc();
      chk("t6_ready_first_run", 32'(in_ready), 0);
      cyc();
      chk("t6_ready_run", 32'(in_ready), 1);

      // Randomized phase
      do_reset();
      in_valid = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 50 == 0) bp_mode = 2'($urandom_range(3));
         if ($urandom_range(99) < 3) enable = !enable;
         start_value = $urandom_range(15);
         clear = $urandom_range(99) < 1;
         src_step(60, 3, 3);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
